// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN constants plus the UART image assembler and byte receiver state encodings.
package cnn_pkg;
  localparam int IMAGE_SIZE = 28;
  localparam int PIXEL_DEPTH = 8;
  localparam int CLASSIFICATIONS = 10;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  typedef enum logic [2:0] {HUNT, PIXELS, LABEL, CSUM, HOLD} asm_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART byte receiver with rx synchronizer, false-start rejection and stop-bit check.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       stop_err
);
  import cnn_pkg::*;
  localparam int CW = $clog2(CLKS_PER_BIT);
  rx_state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0] idx, idx_next;
  logic [7:0] shift_next;
  logic valid_next, err_next, rx_m, rx_s, rx_d;
  logic bit_end;
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {rx_m, rx_s, rx_d} <= 3'b111;
      state <= RX_IDLE;
      cnt <= '0;
      idx <= '0;
      data <= '0;
      byte_valid <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      {rx_m, rx_s, rx_d} <= {rx, rx_m, rx_s};
      state <= state_next;
      cnt <= cnt_next;
      idx <= idx_next;
      data <= shift_next;
      byte_valid <= valid_next;
      stop_err <= err_next;
    end
  end
  always_comb begin
    state_next = state;
    cnt_next = cnt + 1'b1;
    idx_next = idx;
    shift_next = data;
    valid_next = 1'b0;
    err_next = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_next = '0;
        state_next = (rx_d && !rx_s) ? RX_START : RX_IDLE;
      end
      RX_START: if (cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
        cnt_next = '0;
        idx_next = '0;
        state_next = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (bit_end) begin
        cnt_next = '0;
        shift_next = {rx_s, data[7:1]};
        idx_next = idx + 3'd1;
        state_next = (idx == 3'd7) ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (bit_end) begin
        valid_next = rx_s;
        err_next = !rx_s;
        state_next = RX_IDLE;
      end
      default: state_next = RX_IDLE;
    endcase
  end
endmodule

// File: rtl/uart_image_rx.sv
// uart_image_rx: assembles a SYNC/pixels/label/checksum UART frame into the packed CNN input image.
module uart_image_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int IMAGE_SIZE = 28,
  parameter int PIXEL_DEPTH = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int TIMEOUT_CLKS = 1_000_000
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      rx,
  input  logic                                      ready,
  output logic                                      image_valid,
  output logic [IMAGE_SIZE*IMAGE_SIZE*PIXEL_DEPTH-1:0] image,
  output logic [3:0]                                label,
  output logic                                      frame_err,
  output logic                                      busy
);
  import cnn_pkg::*;
  localparam int NPIX = IMAGE_SIZE * IMAGE_SIZE;
  localparam int CW = $clog2(NPIX);
  localparam int TW = $clog2(TIMEOUT_CLKS);
  asm_state_t state, state_next;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;
  logic [7:0] sum, data;
  logic byte_valid, stop_err, active, timeout, err;
  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .data(data),
    .byte_valid(byte_valid),
    .stop_err(stop_err)
  );
  assign active = state inside {PIXELS, LABEL, CSUM};
  assign timeout = timer == TW'(TIMEOUT_CLKS - 1);
  assign image_valid = state == HOLD;
  assign busy = active;
  always_comb begin
    state_next = state;
    err = 1'b0;
    case (state)
      HUNT: state_next = (byte_valid && data == SYNC_BYTE) ? PIXELS : HUNT;
      PIXELS: state_next = (byte_valid && count == CW'(NPIX - 1)) ? LABEL : PIXELS;
      LABEL: begin
        err = byte_valid && data >= 8'(CLASSIFICATIONS);
        state_next = byte_valid ? CSUM : LABEL;
      end
      CSUM: begin
        err = byte_valid && data != sum;
        state_next = byte_valid ? HOLD : CSUM;
      end
      HOLD: state_next = ready ? HUNT : HOLD;
      default: state_next = HUNT;
    endcase
    if (active && (stop_err || timeout)) err = 1'b1;
    if (err) state_next = HUNT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else state <= state_next;
  end
  // HUNT keeps count and sum cleared, so they are fresh on the first pixel after SYNC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      sum <= '0;
      timer <= '0;
      image <= '0;
      label <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err;
      timer <= (byte_valid || !active) ? '0 : timer + 1'b1;
      if (state == HUNT) begin
        count <= '0;
        sum <= '0;
      end
      if (byte_valid && state == PIXELS) begin
        image[count*PIXEL_DEPTH +: PIXEL_DEPTH] <= data;
        count <= count + 1'b1;
        sum <= sum + data;
      end
      if (byte_valid && state == LABEL) begin
        sum <= sum + data;
        if (data < 8'(CLASSIFICATIONS)) label <= data[3:0];
      end
    end
  end
endmodule

// File: tb/tb_uart_image_rx.sv
// tb_uart_image_rx: directed frame-level checks of the UART image receiver with a 2x2 image.
module tb_uart_image_rx;
  localparam int CPB = 16;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, ready = 1'b0;
  logic image_valid, frame_err, busy;
  logic [31:0] image;
  logic [3:0] label;
  int total = 0, passed = 0, failed = 0, err_cnt = 0;
  uart_image_rx #(.CLKS_PER_BIT(CPB), .IMAGE_SIZE(2), .TIMEOUT_CLKS(2000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .ready(ready), .image_valid(image_valid),
    .image(image), .label(label), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (frame_err) err_cnt++;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_bits(input logic [7:0] b, input logic stop);
    @(posedge clk);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop;
  endtask
  task automatic finish_stop;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 1'b1);
    finish_stop();
  endtask
  task automatic send_q(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask
  task automatic wait_evt;
    logic hit = 1'b0;
    for (int i = 0; i < 4 * CPB && !hit; i++) begin
      @(negedge clk);
      hit = dut.byte_valid || dut.stop_err;
    end
    chk("byte_event", hit, 1'b1);
  endtask
  initial begin
    logic [7:0] q[$];
    int e0, n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", image_valid, 0);
    chk("rst_image", image, 0);
    chk("rst_label", label, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    // nominal frame, ready raised after valid
    q = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h07};
    send_q(q);
    send_bits(8'h11, 1'b1);
    wait_evt();
    chk("nom_valid_bv", image_valid, 0);
    @(negedge clk);
    chk("nom_valid", image_valid, 1);
    chk("nom_image", image, 32'h04030201);
    chk("nom_label", label, 7);
    chk("nom_busy", busy, 0);
    chk("nom_err", frame_err, 0);
    ready = 1'b1;
    @(negedge clk);
    chk("nom_drop", image_valid, 0);
    ready = 1'b0;
    finish_stop();
    // bad checksum
    send_q(q);
    send_bits(8'h12, 1'b1);
    wait_evt();
    chk("csum_err_bv", frame_err, 0);
    @(negedge clk);
    chk("csum_err", frame_err, 1);
    chk("csum_valid", image_valid, 0);
    chk("csum_busy", busy, 0);
    @(negedge clk);
    chk("csum_err_pulse", frame_err, 0);
    finish_stop();
    // good frame with ready already high: exactly one valid cycle
    ready = 1'b1;
    q = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'h03};
    send_q(q);
    send_bits(8'hA3, 1'b1);
    wait_evt();
    @(negedge clk);
    chk("rdy_valid", image_valid, 1);
    chk("rdy_image", image, 32'h40302010);
    chk("rdy_label", label, 3);
    @(negedge clk);
    chk("rdy_drop", image_valid, 0);
    ready = 1'b0;
    finish_stop();
    // leading garbage then bad label
    q = '{8'hFF, 8'h00};
    send_q(q);
    chk("garbage_busy", busy, 0);
    send_byte(8'hA5);
    chk("sync_busy", busy, 1);
    q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_q(q);
    send_bits(8'h0A, 1'b1);
    wait_evt();
    @(negedge clk);
    chk("label_err", frame_err, 1);
    chk("label_busy", busy, 0);
    finish_stop();
    send_byte(8'h0E);
    chk("label_after_busy", busy, 0);
    chk("label_kept", label, 3);
    // glitch inside a frame, then a stop error
    send_byte(8'hA5);
    e0 = err_cnt;
    @(posedge clk);
    rx = 1'b0;
    repeat (3) @(posedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    @(negedge clk);
    chk("glitch_noerr", err_cnt, e0);
    chk("glitch_busy", busy, 1);
    send_byte(8'h01);
    send_bits(8'h55, 1'b0);
    wait_evt();
    @(negedge clk);
    chk("stop_err", frame_err, 1);
    chk("stop_busy", busy, 0);
    finish_stop();
    // bytes during HOLD are discarded
    q = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h07, 8'h11};
    send_q(q);
    chk("hold_valid0", image_valid, 1);
    e0 = err_cnt;
    q = '{8'hA5, 8'h09, 8'h09, 8'h09, 8'h09, 8'h01, 8'h25};
    send_q(q);
    @(negedge clk);
    chk("hold_valid", image_valid, 1);
    chk("hold_image", image, 32'h04030201);
    chk("hold_label", label, 7);
    chk("hold_busy", busy, 0);
    chk("hold_noerr", err_cnt, e0);
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("hold_drop", image_valid, 0);
    ready = 1'b0;
    // inter-byte timeout
    send_byte(8'hA5);
    send_bits(8'h01, 1'b1);
    wait_evt();
    n = 0;
    while (n < 3000 && !frame_err) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_gap", (n >= 1999 && n <= 2001), 1'b1);
    @(negedge clk);
    chk("timeout_busy", busy, 0);
    // reset mid-frame
    e0 = err_cnt;
    q = '{8'hA5, 8'h01, 8'h02};
    send_q(q);
    @(posedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mrst_valid", image_valid, 0);
    chk("mrst_image", image, 0);
    chk("mrst_label", label, 0);
    chk("mrst_busy", busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("mrst_noerr", err_cnt, e0);
    q = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h07};
    send_q(q);
    send_bits(8'h11, 1'b1);
    wait_evt();
    @(negedge clk);
    chk("after_valid", image_valid, 1);
    chk("after_image", image, 32'h04030201);
    chk("after_label", label, 7);
    finish_stop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_image_rx.md
# uart_image_rx

Serial front end of the CNN top level: receives one 28×28 8-bit image plus its expected label over a UART line, validates the frame, and presents the packed image to the CNN controller with a valid/ready handshake. It fills the input-image register that the convolution layer consumes. It replaces simulation-only image loading with a synthesizable path from the host.

## Interface
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- IMAGE_SIZE, 28: image height/width; frame carries IMAGE_SIZE² pixel bytes.
- PIXEL_DEPTH, 8: bits per pixel; fixed at 8, one UART byte per pixel.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CLKS, 1_000_000: maximum idle gap between bytes inside a frame.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- rx  in  1  UART line, idle high, 8N1, LSB first; asynchronous to clk.
- ready  in  1  CNN controller accepts the image.
- image_valid  out  1  packed image and label are complete and checked.
- image  out  IMAGE_SIZE²·8  pixel at row r, col c, p = r·IMAGE_SIZE+c, occupies bits [p·8+7 : p·8].
- label  out  4  expected class, 0–9.
- frame_err  out  1  one-cycle pulse when a frame is dropped.
- busy  out  1  high while a frame is in progress: after SYNC, before valid or error.

## Operation
- Byte receiver: 2-flop synchronizer on rx. A falling edge starts the byte. Start bit is re-checked at CLKS_PER_BIT/2; if high, it is a false start and the receiver returns to idle. Eight data bits are then sampled at CLKS_PER_BIT intervals, then the stop bit. Stop = 1 gives a byte_valid pulse. Stop = 0 gives a stop_err pulse and drops the byte. Either way the receiver returns to idle and may detect the next start immediately.
- Assembler FSM states: HUNT, PIXELS, LABEL, CSUM, HOLD.
  - HUNT: bytes other than SYNC_BYTE are ignored. SYNC_BYTE clears pixel counter and checksum, then goes to PIXELS.
  - PIXELS: each byte is written to image slot [count] and added to the sum. After IMAGE_SIZE² bytes, go to LABEL.
  - LABEL: the byte is added to the sum. If value > 9, go to error. Otherwise latch label[3:0] and go to CSUM.
  - CSUM: if the byte equals the 8-bit sum mod 256 of pixels+label, go to HOLD and assert image_valid. Otherwise go to error.
  - HOLD: image_valid stays high; image and label stay stable. The handshake completes on the cycle with image_valid && ready; go to HUNT. Bytes received in HOLD are discarded, never written.
  - Error: pulse frame_err, go to HUNT. The image register keeps partial contents; they are not valid.
- Any stop_err in PIXELS, LABEL or CSUM aborts to error. A stop_err in HUNT or HOLD is ignored.
- Timeout counter clears on every byte_valid. When it reaches TIMEOUT_CLKS in PIXELS, LABEL or CSUM, go to error.
- A SYNC_BYTE value inside PIXELS is ordinary pixel data; there is no resync.

## Timing
- Reset values: image_valid 0, image all 0, label 0, frame_err 0, busy 0. FSM in HUNT, byte receiver idle.
- rst mid-frame or mid-HOLD aborts immediately, with no frame_err pulse.
- byte_valid is registered one cycle after the stop-bit sample.
- image_valid rises the cycle after the CSUM byte_valid.
- frame_err rises the cycle after the offending byte_valid or stop_err, or on the timeout cycle.
- ready may be high before valid. The transfer then takes exactly one valid cycle; image_valid falls the next cycle.
- busy rises with the PIXELS entry and falls on entry to HOLD or HUNT.
- Byte write and checksum update happen on the byte_valid cycle, with no stall.

## Structure
- Shared package cnn_pkg holds:
  - IMAGE_SIZE, PIXEL_DEPTH, CLASSIFICATIONS;
  - SYNC_BYTE;
  - assembler state encoding, which the CNN top level reuses for debug.
- Sub-module uart_rx_byte: synchronizer, bit timer, shift register, byte_valid/stop_err outputs.
- The assembler FSM, pixel counter, checksum and timeout counter live in uart_image_rx.

## Test plan
All scenarios use CLKS_PER_BIT=16, IMAGE_SIZE=2, TIMEOUT_CLKS=2000.
- Nominal frame: send A5 01 02 03 04 07 11. Expect image_valid one cycle after the last byte, image=32'h04030201, label=7, busy low. With ready=1 one cycle later, image_valid drops.
- Bad checksum: send A5 01 02 03 04 07 12. Expect one frame_err pulse, no image_valid. A following good frame is accepted.
- Bad label and leading garbage: send FF 00 A5 01 02 03 04 0A 0E. Expect FF and 00 ignored, then frame_err on the label byte.
- Noise and stop error: a 3-cycle low glitch on rx produces no byte. A byte with stop=0 after A5 01 gives frame_err and a return to HUNT.
- Hold and timeout: with ready=0 after a good frame, send A5 09 09 09 09 01 25. Expect image unchanged and image_valid held. Separately, send A5 01 then go idle. Expect frame_err 2000 cycles after the last byte_valid.
- Reset mid-frame: assert rst after A5 01 02. Expect all outputs 0 and no frame_err. The nominal frame then succeeds.
